// File: rtl/puf_eval_ctrl.sv
// Arbiter-PUF evaluation sequencer: applies a challenge, fires N_EVAL launches, majority-votes the arbiter samples.
// Optional build macro PUF_STABILITY_EN adds the 'stable' unanimity flag output.
module puf_eval_ctrl #(
    parameter int C_LENGTH   = 64,
    parameter int N_EVAL     = 5,
    parameter int SETTLE_CYC = 4,
    parameter int SAMPLE_CYC = 4,
    parameter int RELAX_CYC  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [C_LENGTH-1:0]          challenge_in,
    output logic                         busy,
    output logic [C_LENGTH-1:0]          challenge_out,
    output logic                         launch,
    output logic                         arb_clr,
    input  logic                         arb_out,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic                         resp,
    output logic [$clog2(N_EVAL+1)-1:0]  ones_count,
`ifdef PUF_STABILITY_EN
    output logic                         stable,
`endif
    output logic [2:0]                   state_dbg
);

    localparam int EW      = $clog2(N_EVAL + 1);
    localparam int MAX_AB  = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
    localparam int MAX_CYC = (MAX_AB > RELAX_CYC) ? MAX_AB : RELAX_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_LAUNCH = 3'd2,
        S_SAMPLE = 3'd3,
        S_RELAX  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cyc_cnt;
    logic [EW-1:0]   eval_cnt;
    logic [1:0]      arb_sync;
    logic            launch_nxt;
    logic            arb_clr_nxt;
    logic [EW:0]     twice_ones;
    logic            accept;

    // Handshake: resp_valid stays high in DONE until resp_valid && resp_ready on a rising edge;
    // resp, ones_count and challenge_out are stable for as long as resp_valid is high.
    assign accept     = (state == S_IDLE) && start;
    assign twice_ones = {ones_count, 1'b0};
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        launch_nxt  = 1'b0;
        arb_clr_nxt = 1'b1;
        busy        = 1'b1;
        resp_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_SETUP;
            end
            S_SETUP: begin
                if (cyc_cnt == CW'(SETTLE_CYC - 1)) state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                if (cyc_cnt == CW'(SAMPLE_CYC - 1)) state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                state_nxt = S_RELAX;
            end
            S_RELAX: begin
                if (cyc_cnt == CW'(RELAX_CYC - 1))
                    state_nxt = (eval_cnt == EW'(N_EVAL)) ? S_DONE : S_SETUP;
            end
            S_DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // Launch/clear are decoded from the next state so the registered copies line up with the state.
        if (state_nxt == S_LAUNCH || state_nxt == S_SAMPLE) begin
            launch_nxt  = 1'b1;
            arb_clr_nxt = 1'b0;
        end
    end

    // Registered so the delay-chain launch edge never carries state-decode glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            launch  <= 1'b0;
            arb_clr <= 1'b1;
        end else begin
            launch  <= launch_nxt;
            arb_clr <= arb_clr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) arb_sync <= 2'b00;
        else        arb_sync <= {arb_sync[0], arb_out};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
        end else if (state_nxt != state || state == S_IDLE || state == S_DONE) begin
            cyc_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            challenge_out <= '0;
            ones_count    <= '0;
            eval_cnt      <= '0;
            resp          <= 1'b0;
        end else begin
            if (accept) begin
                challenge_out <= challenge_in;
                ones_count    <= '0;
                eval_cnt      <= '0;
                resp          <= 1'b0;
            end
            if (state == S_SAMPLE) begin
                if (arb_sync[1] && ones_count != EW'(N_EVAL))
                    ones_count <= ones_count + EW'(1);
                if (eval_cnt != EW'(N_EVAL))
                    eval_cnt <= eval_cnt + EW'(1);
            end
            // Strict majority; an even-N tie resolves to 0.
            if (state == S_RELAX && state_nxt == S_DONE)
                resp <= (twice_ones > (EW + 1)'(N_EVAL));
        end
    end

`ifdef PUF_STABILITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b0;
        end else if (accept) begin
            stable <= 1'b0;
        end else if (state == S_RELAX && state_nxt == S_DONE) begin
            stable <= (ones_count == '0) || (ones_count == EW'(N_EVAL));
        end
    end
`endif

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Scoreboard bench for puf_eval_ctrl: a default (N_EVAL=5) instance and an N_EVAL=4 instance.
// Define PUF_STABILITY_EN for both the RTL and this bench to cover the stable flag.
module tb_puf_eval_ctrl;

    localparam int CL = 64;
    localparam int XW = 8 + CL + 3 + 1 + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, start4;
    logic [CL-1:0] challenge_in;
    logic          arb_out;
    logic          resp_ready, resp_ready4;

    logic          busy, launch, arb_clr, resp_valid, resp, stable;
    logic [CL-1:0] challenge_out;
    logic [2:0]    ones_count, state_dbg;
    logic          busy4, launch4, arb_clr4, resp_valid4, resp4, stable4;
    logic [CL-1:0] challenge_out4;
    logic [2:0]    ones_count4, state_dbg4;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int start_cyc = 0;
    int overlap_cnt = 0;
    logic [12:0] launch_rec, clr_rec;
    logic [XW-1:0] exp_q[$];
    logic [XW-1:0] exp4_q[$];
    logic use4 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    puf_eval_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .challenge_in(challenge_in),
        .busy(busy), .challenge_out(challenge_out), .launch(launch), .arb_clr(arb_clr),
        .arb_out(arb_out), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp(resp),
        .ones_count(ones_count),
`ifdef PUF_STABILITY_EN
        .stable(stable),
`endif
        .state_dbg(state_dbg)
    );

    puf_eval_ctrl #(.N_EVAL(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .challenge_in(challenge_in),
        .busy(busy4), .challenge_out(challenge_out4), .launch(launch4), .arb_clr(arb_clr4),
        .arb_out(arb_out), .resp_valid(resp_valid4), .resp_ready(resp_ready4), .resp(resp4),
        .ones_count(ones_count4),
`ifdef PUF_STABILITY_EN
        .stable(stable4),
`endif
        .state_dbg(state_dbg4)
    );

`ifndef PUF_STABILITY_EN
    assign stable  = 1'b0;
    assign stable4 = 1'b0;
`endif

    wire sel_launch = use4 ? launch4     : launch;
    wire sel_valid  = use4 ? resp_valid4 : resp_valid;
    wire sel_busy   = use4 ? busy4       : busy;
    wire sel_resp   = use4 ? resp4       : resp;
    wire [CL-1:0] sel_chal = use4 ? challenge_out4 : challenge_out;

    // Monitor for the default instance: compare each new response against the queue head.
    initial begin
        logic pv;
        logic [XW-1:0] a, e;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && resp_valid && !pv) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL resp_unexpected: got resp=%0b ones=%0d with empty queue", resp, ones_count);
                end else begin
                    e = exp_q.pop_front();
                    a = {8'(cyc - start_cyc), challenge_out, ones_count, resp, 1'b0};
`ifdef PUF_STABILITY_EN
                    a[0] = stable;
`else
                    a[0] = e[0];
`endif
                    if (a !== e) begin
                        fails++;
                        $display("FAIL resp5: got lat=%0d chal=%h ones=%0d resp=%0b stable=%0b, want lat=%0d chal=%h ones=%0d resp=%0b stable=%0b",
                                 a[XW-1 -: 8], a[CL+4 : 5], a[4:2], a[1], a[0],
                                 e[XW-1 -: 8], e[CL+4 : 5], e[4:2], e[1], e[0]);
                    end
                end
            end
            pv = resp_valid;
        end
    end

    // Monitor for the N_EVAL=4 instance.
    initial begin
        logic pv;
        logic [XW-1:0] a, e;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && resp_valid4 && !pv) begin
                tests++;
                if (exp4_q.size() == 0) begin
                    fails++;
                    $display("FAIL resp4_unexpected: got resp=%0b ones=%0d with empty queue", resp4, ones_count4);
                end else begin
                    e = exp4_q.pop_front();
                    a = {8'(cyc - start_cyc), challenge_out4, ones_count4, resp4, 1'b0};
`ifdef PUF_STABILITY_EN
                    a[0] = stable4;
`else
                    a[0] = e[0];
`endif
                    if (a !== e) begin
                        fails++;
                        $display("FAIL resp4: got lat=%0d ones=%0d resp=%0b stable=%0b, want lat=%0d ones=%0d resp=%0b stable=%0b",
                                 a[XW-1 -: 8], a[4:2], a[1], a[0], e[XW-1 -: 8], e[4:2], e[1], e[0]);
                    end
                end
            end
            pv = resp_valid4;
        end
    end

    // Waveform recorder for the first 13 cycles after a start, plus launch/clear overlap watch.
    initial begin
        int d;
        forever begin
            @(negedge clk);
            d = cyc - start_cyc;
            if (d >= 0 && d < 13) begin
                launch_rec[d] = launch;
                clr_rec[d]    = arb_clr;
            end
            if (launch && arb_clr)   overlap_cnt++;
            if (launch4 && arb_clr4) overlap_cnt++;
        end
    end

    task automatic check(input string name, input logic [CL-1:0] act, input logic [CL-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic issue_start(input logic d4, input logic [CL-1:0] chal);
        use4 = d4;
        @(negedge clk);
        challenge_in = chal;
        start_cyc = cyc + 1;
        if (d4) start4 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start4 = 1'b0;
        check("chal_latched", sel_chal, chal);
    endtask

    // Drive one arbiter value per eval, held from launch rise until launch falls.
    task automatic drive_evals(input int nev, input logic [4:0] pat, output bit ok);
        int t;
        ok = 1'b1;
        for (int i = 0; i < nev; i++) begin
            t = 0;
            while (!sel_launch && t < 100) begin @(negedge clk); t++; end
            if (t >= 100) begin
                tests++; fails++; ok = 1'b0;
                $display("FAIL launch_timeout: eval %0d got no launch, want launch=1", i);
                return;
            end
            arb_out = pat[i];
            t = 0;
            while (sel_launch && t < 100) begin @(negedge clk); t++; end
            arb_out = 1'b0;
        end
    endtask

    task automatic run_vec(input logic d4, input logic [CL-1:0] chal, input logic [4:0] pat,
                           input int nev, input logic [2:0] x_ones, input logic x_resp,
                           input logic x_stable, input bit hold_test, input bit wave_check);
        bit ok;
        int t;
        logic [XW-1:0] e;
        e = {8'(nev * 13), chal, x_ones, x_resp, x_stable};
        if (d4) exp4_q.push_back(e); else exp_q.push_back(e);
        issue_start(d4, chal);
        drive_evals(nev, pat, ok);
        if (!ok) return;
        if (wave_check) begin
            check("launch_wave", 64'(launch_rec), 64'h1F0);
            check("arb_clr_wave", 64'(clr_rec), 64'h1E0F);
        end
        t = 0;
        while (!sel_valid && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) begin
            tests++; fails++;
            $display("FAIL valid_timeout: resp_valid=0, want 1");
            return;
        end
        if (hold_test) begin
            for (int j = 0; j < 10; j++) begin
                check("hold_valid", 64'(sel_valid), 64'd1);
                check("hold_resp", 64'(sel_resp), 64'(x_resp));
                check("hold_chal", sel_chal, chal);
                @(negedge clk);
                if (j == 3) begin
                    challenge_in = ~chal;
                    if (d4) start4 = 1'b1; else start = 1'b1;
                end else begin
                    start = 1'b0;
                    start4 = 1'b0;
                end
            end
            start = 1'b0;
            start4 = 1'b0;
        end
        if (d4) resp_ready4 = 1'b1; else resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        resp_ready4 = 1'b0;
        check("ack_valid_low", 64'(sel_valid), 64'd0);
        check("ack_busy_low", 64'(sel_busy), 64'd0);
        if (hold_test) check("idle_chal_kept", sel_chal, chal);
    endtask

    task automatic reset_mid_run();
        int t;
        int seen;
        issue_start(1'b0, 64'h0123_4567_89AB_CDEF);
        arb_out = 1'b1;
        seen = 0;
        t = 0;
        while (seen < 3 && t < 200) begin
            @(negedge clk);
            t++;
            if (launch && cyc - start_cyc == 4 + 13 * seen) seen++;
        end
        if (seen < 3) begin
            tests++; fails++;
            $display("FAIL eval3_timeout: saw %0d launches, want 3", seen);
        end
        check("pre_reset_ones", 64'(ones_count), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_launch", 64'(launch), 64'd0);
        check("rst_arb_clr", 64'(arb_clr), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ones", 64'(ones_count), 64'd0);
        check("rst_chal", challenge_out, 64'd0);
        arb_out = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        start4 = 1'b0;
        challenge_in = '0;
        arb_out = 1'b0;
        resp_ready = 1'b0;
        resp_ready4 = 1'b0;
        start_cyc = -100;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_launch", 64'(launch), 64'd0);
        check("reset_arb_clr", 64'(arb_clr), 64'd1);
        check("reset_valid", 64'(resp_valid), 64'd0);
        check("reset_resp", 64'(resp), 64'd0);
        check("reset_ones", 64'(ones_count), 64'd0);
        check("reset_chal", challenge_out, 64'd0);
`ifdef PUF_STABILITY_EN
        check("reset_stable", 64'(stable), 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        resp_ready = 1'b1;
        @(negedge clk);
        check("idle_ready_ignored", 64'(busy), 64'd0);
        resp_ready = 1'b0;

        // chal, per-eval arbiter bits (bit i = eval i), evals, ones, resp, stable
        run_vec(1'b0, 64'hA5A5_0000_FFFF_1234, 5'b11111, 5, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        run_vec(1'b0, 64'h1111_2222_3333_4444, 5'b10011, 5, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        run_vec(1'b0, 64'hDEAD_BEEF_0000_0001, 5'b01100, 5, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        run_vec(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 5'b00000, 5, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        reset_mid_run();
        run_vec(1'b0, 64'h8000_0000_0000_0001, 5'b10101, 5, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        run_vec(1'b1, 64'h0F0F_0F0F_0F0F_0F0F, 5'b00011, 4, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        run_vec(1'b1, 64'h1234_5678_9ABC_DEF0, 5'b00111, 4, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("no_launch_clr_overlap", 64'(overlap_cnt), 64'd0);
        check("queue5_drained", 64'(exp_q.size()), 64'd0);
        check("queue4_drained", 64'(exp4_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
